// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall-bit indices,
// canonical stall vectors and controller state encodings.
`default_nettype none

package pipe_ctrl_pkg;

  localparam int StallPc  = 0;
  localparam int StallIf  = 1;
  localparam int StallId  = 2;
  localparam int StallEx  = 3;
  localparam int StallMem = 4;
  localparam int StallWb  = 5;

  localparam logic [5:0] StallNone   = 6'b000000;
  localparam logic [5:0] StallIdVec  = 6'b000111;
  localparam logic [5:0] StallExVec  = 6'b001111;
  localparam logic [5:0] StallPcOnly = 6'b000001;

  typedef enum logic [1:0] {
    CtrlRun       = 2'd0,
    CtrlMcWait    = 2'd1,
    CtrlFlushHold = 2'd2
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use stalls, multi-cycle EX occupancy and
// exception flushes into a per-stage stall vector, flush pulse and stall statistic.
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int FLUSH_HOLD = 1,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_len_i,
  input  logic              flush_req_i,
  input  logic [31:0]       flush_pc_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              mc_done_o,
  output logic              busy_o,
  output logic [STAT_W-1:0] stall_cnt_o
);

  ctrl_state_t       state, state_nxt;
  logic [CNT_W-1:0]  mc_cnt, mc_cnt_nxt;
  logic [2:0]        hold_cnt, hold_cnt_nxt;
  logic [STAT_W-1:0] stall_cnt;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CtrlRun;
      mc_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      mc_cnt   <= mc_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mc_cnt_nxt   = mc_cnt;
    hold_cnt_nxt = hold_cnt;
    stall        = StallNone;
    flush        = 1'b0;
    new_pc       = 32'h0;
    mc_done      = 1'b0;

    if (flush_req_i) begin
      flush      = 1'b1;
      new_pc     = flush_pc_i;
      mc_cnt_nxt = '0;
      if (FLUSH_HOLD == 0) begin
        state_nxt    = CtrlRun;
        hold_cnt_nxt = '0;
      end else begin
        state_nxt    = CtrlFlushHold;
        hold_cnt_nxt = 3'(FLUSH_HOLD);
      end
    end else begin
      case (state)
        CtrlRun: begin
          // Lengths 0 and 1 complete in the start cycle, so they never hold EX.
          if (mc_start_i && (mc_len_i >= CNT_W'(2))) begin
            stall      = StallExVec;
            mc_cnt_nxt = mc_len_i - CNT_W'(2);
            state_nxt  = CtrlMcWait;
          end else if (stallreq_id_i) begin
            stall = StallIdVec;
          end
        end
        CtrlMcWait: begin
          if (mc_cnt != '0) begin
            stall      = StallExVec;
            mc_cnt_nxt = mc_cnt - CNT_W'(1);
          end else begin
            mc_done   = 1'b1;
            stall     = stallreq_id_i ? StallIdVec : StallNone;
            state_nxt = CtrlRun;
          end
        end
        CtrlFlushHold: begin
          stall        = StallPcOnly;
          hold_cnt_nxt = hold_cnt - 3'd1;
          if (hold_cnt <= 3'd1) begin
            hold_cnt_nxt = '0;
            state_nxt    = CtrlRun;
          end
        end
        default: begin
          state_nxt = CtrlRun;
        end
      endcase
    end
  end

  // Outputs are forced quiet during reset because they are combinational from inputs.
  assign stall_o   = rst ? StallNone : stall;
  assign flush_o   = rst ? 1'b0 : flush;
  assign new_pc_o  = rst ? 32'h0 : new_pc;
  assign mc_done_o = rst ? 1'b0 : mc_done;
  assign busy_o    = (state != CtrlRun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((stall_o != StallNone) && (stall_cnt != {STAT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STAT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

`default_nettype wire
